// File: rtl/datagram_uart_tx_pkg.sv
// datagram_uart_tx_pkg: constants and state encoding shared with the display-side receiver
package datagram_uart_tx_pkg;
    localparam int MESSAGE_SIZE = 16;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} tx_state_t;
endpackage

// File: rtl/datagram_uart_tx_uart_byte_tx.sv
// uart_byte_tx: single 8N1 byte shifter; a start in the final stop-bit cycle chains the next byte gaplessly
module uart_byte_tx
    import datagram_uart_tx_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       last,
    output logic       tx
);
    localparam int CW = $clog2(BAUD_DIV);
    tx_state_t state, state_n;
    logic [CW-1:0] baud;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic bit_end, load;
    assign bit_end = baud == CW'(BAUD_DIV - 1);
    assign busy = state != IDLE;
    assign last = state == STOP && bit_end;
    assign load = start && (!busy || last);
    assign tx = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    // bit-phase state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    // advance start -> 8 data bits -> stop at each bit boundary
    always_comb begin
        state_n = state;
        if (load)
            state_n = START;
        else if (bit_end && busy)
            state_n = state == START ? DATA : state == STOP ? IDLE : bit_idx == 3'd7 ? STOP : DATA;
    end
    // baud timing, bit counting and LSB-first shifting
    always_ff @(posedge clk) begin
        if (rst) begin
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (load) begin
            baud    <= '0;
            bit_idx <= '0;
            shift   <= data;
        end else if (busy) begin
            baud <= bit_end ? '0 : baud + 1'b1;
            if (bit_end && state == DATA) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/datagram_uart_tx.sv
// datagram_uart_tx: frames a snapshotted datagram as sync, payload bytes and XOR checksum over 8N1 UART
module datagram_uart_tx
    import datagram_uart_tx_pkg::*;
#(
    parameter int         MSG_BITS  = MESSAGE_SIZE,
    parameter int         BAUD_DIV  = 868,
    parameter logic [7:0] SYNC_BYTE = datagram_uart_tx_pkg::SYNC_BYTE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MSG_BITS-1:0] datagram,
    input  logic                send,
    output logic                busy,
    output logic                done,
    output logic                TxD
);
    localparam int NBYTES = (MSG_BITS + 7) / 8;
    localparam int PW = NBYTES * 8;
    localparam int IW = $clog2(NBYTES + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES + 1);
    tx_state_t state, state_n;
    logic [MSG_BITS-1:0] snap;
    logic [PW-1:0] padded;
    logic [IW-1:0] idx;
    logic [7:0] chk, next_byte;
    logic accept, advance, byte_busy, byte_last;
    assign accept = send && (state == IDLE || state == DONE);
    assign advance = state == START && byte_last && idx != LAST_IDX;
    assign padded = PW'(snap);
    assign busy = byte_busy;
    assign done = state == DONE;
    // checksum over the payload, and the byte that follows the one currently on the wire
    always_comb begin
        chk = '0;
        for (int k = 0; k < NBYTES; k++) chk ^= padded[8*k +: 8];
        next_byte = chk;
        for (int k = 0; k < NBYTES; k++)
            if (idx == IW'(k)) next_byte = padded[8*k +: 8];
    end
    uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_byte (
        .clk   (clk),
        .rst   (rst),
        .start (accept || advance),
        .data  (accept ? SYNC_BYTE : next_byte),
        .busy  (byte_busy),
        .last  (byte_last),
        .tx    (TxD)
    );
    // frame state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    // START spans the whole frame; the byte shifter owns the per-bit phases
    always_comb begin
        state_n = accept ? START
                : state == START && byte_last && idx == LAST_IDX ? DONE
                : state == DONE ? IDLE
                : state;
    end
    // byte index and datagram snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            snap <= '0;
        end else if (accept) begin
            idx  <= '0;
            snap <= datagram;
        end else if (advance) begin
            idx <= idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_datagram_uart_tx.sv
// tb_datagram_uart_tx: table-driven frames with a UART-decoding scoreboard on two configurations
module tb_datagram_uart_tx;
    localparam int B = 4;
    typedef struct {
        logic [15:0] dg;
        logic [7:0]  b0, b1, c;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [15:0] dg16 = '0;
    logic [11:0] dg12 = '0;
    logic send16 = 1'b0, send12 = 1'b0;
    logic busy16, done16, txd16, busy12, done12, txd12;
    logic [7:0] exp16[$], exp12[$];
    int errors = 0, checks = 0;
    bit drop = 1'b0;

    always #5 clk = ~clk;

    datagram_uart_tx #(.MSG_BITS(16), .BAUD_DIV(B), .SYNC_BYTE(8'hA5)) dut16 (
        .clk(clk), .rst(rst), .datagram(dg16), .send(send16),
        .busy(busy16), .done(done16), .TxD(txd16));

    datagram_uart_tx #(.MSG_BITS(12), .BAUD_DIV(B), .SYNC_BYTE(8'hA5)) dut12 (
        .clk(clk), .rst(rst), .datagram(dg12), .send(send12),
        .busy(busy12), .done(done12), .TxD(txd12));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // decode the line at mid-bit and compare each byte against the expected queue
    task automatic monitor(input bit w);
        logic [7:0] d, e;
        logic stop;
        forever begin
            @(negedge clk);
            if ((w ? txd12 : txd16) == 1'b0) begin
                repeat (B/2) @(negedge clk);
                if ((w ? txd12 : txd16) == 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (B) @(negedge clk);
                        d[i] = w ? txd12 : txd16;
                    end
                    repeat (B) @(negedge clk);
                    stop = w ? txd12 : txd16;
                    if (!drop) begin
                        check(w ? "stop12" : "stop16", {31'd0, stop}, 32'd1);
                        checks++;
                        if ((w ? exp12.size() : exp16.size()) == 0) begin
                            errors++;
                            $display("FAIL unexpected_byte%0s: got %0h expected none", w ? "12" : "16", d);
                        end else begin
                            if (w) e = exp12.pop_front();
                            else e = exp16.pop_front();
                            if (d !== e) begin
                                errors++;
                                $display("FAIL byte%0s: got %0h expected %0h", w ? "12" : "16", d, e);
                            end
                        end
                    end
                end
            end
        end
    endtask

    initial monitor(1'b0);
    initial monitor(1'b1);

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // one 16-bit frame; optionally disturb datagram/send mid-frame
    task automatic frame16(input logic [15:0] dg, input logic [7:0] b0, b1, c, input bit poke);
        int n, extra;
        exp16.push_back(8'hA5);
        exp16.push_back(b0);
        exp16.push_back(b1);
        exp16.push_back(c);
        @(negedge clk);
        dg16 = dg;
        send16 = 1'b1;
        @(negedge clk);
        send16 = 1'b0;
        check("start_busy", {31'd0, busy16}, 32'd1);
        check("start_txd", {31'd0, txd16}, 32'd0);
        n = 1;
        while (busy16 && n < 400) begin
            @(negedge clk);
            send16 = poke && n == 50;
            if (poke && n == 50) dg16 = ~dg;
            if (busy16) n++;
        end
        send16 = 1'b0;
        check("busy_len", n, 32'd160);
        check("done_pulse", {31'd0, done16}, 32'd1);
        @(negedge clk);
        check("done_single", {31'd0, done16}, 32'd0);
        check("sb_drain", exp16.size(), 32'd0);
        if (poke) begin
            extra = 0;
            repeat (100) begin
                @(negedge clk);
                if (busy16 || done16) extra++;
            end
            check("no_requeue", extra, 32'd0);
        end
    endtask

    initial begin
        vec_t tbl[5];
        int n;
        tbl[0] = '{16'h3C12, 8'h12, 8'h3C, 8'h2E};
        tbl[1] = '{16'h0000, 8'h00, 8'h00, 8'h00};
        tbl[2] = '{16'hFFFF, 8'hFF, 8'hFF, 8'h00};
        tbl[3] = '{16'hA55A, 8'h5A, 8'hA5, 8'hFF};
        tbl[4] = '{16'h8001, 8'h01, 8'h80, 8'h81};

        repeat (3) @(negedge clk);
        check("rst_txd", {31'd0, txd16}, 32'd1);
        check("rst_busy", {31'd0, busy16}, 32'd0);
        check("rst_done", {31'd0, done16}, 32'd0);
        check("rst_txd12", {31'd0, txd12}, 32'd1);
        rst = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (!txd16 || busy16 || done16) n++;
        end
        check("idle_hold", n, 32'd0);

        foreach (tbl[i]) frame16(tbl[i].dg, tbl[i].b0, tbl[i].b1, tbl[i].c, 1'b0);

        frame16(16'h00F0, 8'hF0, 8'h00, 8'hF0, 1'b1);

        exp12.push_back(8'hA5);
        exp12.push_back(8'hBC);
        exp12.push_back(8'h0A);
        exp12.push_back(8'hB6);
        @(negedge clk);
        dg12 = 12'hABC;
        send12 = 1'b1;
        @(negedge clk);
        send12 = 1'b0;
        dg12 = 12'h123;
        n = 1;
        while (busy12 && n < 400) begin
            @(negedge clk);
            if (busy12) n++;
        end
        check("busy_len12", n, 32'd160);
        check("done12", {31'd0, done12}, 32'd1);
        @(negedge clk);
        check("sb_drain12", exp12.size(), 32'd0);

        for (int k = 0; k < 2; k++) begin
            exp16.push_back(8'hA5);
            exp16.push_back(8'h12);
            exp16.push_back(8'h3C);
            exp16.push_back(8'h2E);
        end
        @(negedge clk);
        dg16 = 16'h3C12;
        send16 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!done16 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("held_done1", {31'd0, done16}, 32'd1);
        @(negedge clk);
        check("b2b_busy", {31'd0, busy16}, 32'd1);
        check("b2b_txd", {31'd0, txd16}, 32'd0);
        send16 = 1'b0;
        n = 0;
        while (!done16 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("held_done2", {31'd0, done16}, 32'd1);
        repeat (20) @(negedge clk);
        check("held_stop", {31'd0, busy16}, 32'd0);
        check("sb_drain_b2b", exp16.size(), 32'd0);

        drop = 1'b1;
        @(negedge clk);
        dg16 = 16'h1234;
        send16 = 1'b1;
        @(negedge clk);
        send16 = 1'b0;
        repeat (60) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy16}, 32'd1);
        rst = 1'b1;
        dg16 = 16'h5555;
        send16 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send16 = 1'b0;
        check("midrst_txd", {31'd0, txd16}, 32'd1);
        check("midrst_busy", {31'd0, busy16}, 32'd0);
        check("midrst_done", {31'd0, done16}, 32'd0);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy16 || done16 || !txd16) n++;
        end
        check("rst_quiet", n, 32'd0);
        drop = 1'b0;
        frame16(16'hBEEF, 8'hEF, 8'hBE, 8'h51, 1'b0);

        repeat (10) @(negedge clk);
        check("final_empty16", exp16.size(), 32'd0);
        check("final_empty12", exp12.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/datagram_uart_tx.md
# datagram_uart_tx

Serialises the control core's `datagram` bus into a framed 8N1 UART byte stream for the display board. It sits directly downstream of the control core. On a send request it snapshots the datagram, then transmits a sync byte, the payload bytes LSB-first and an XOR checksum on a single `TxD` line. Busy/done handshaking lets the control core pace frames.

## Interface
Parameters:
- `MSG_BITS`, default `MESSAGE_SIZE` from the shared package: datagram width.
- `BAUD_DIV`, default 868 (100 MHz / 115200): clock cycles per UART bit, ≥2.
- `SYNC_BYTE`, default 8'hA5: frame header byte.

Ports:
- `clk`, input, 1: system clock (100 MHz). One clock; reset is synchronous and active-high.
- `rst`, input, 1: synchronous active-high reset.
- `datagram`, input, `MSG_BITS`: message to send; sampled only on an accepted `send`.
- `send`, input, 1: frame request; accepted only in a cycle where `busy`=0.
- `busy`, output, 1: frame in progress.
- `done`, output, 1: one-cycle pulse when a frame finishes.
- `TxD`, output, 1: serial line; idles high.

## Operation
- Derived constant: NBYTES = ceil(`MSG_BITS`/8). Payload byte k = datagram[8k+7:8k], with missing high bits zero-padded.
- Frame on the wire: `SYNC_BYTE`, then payload bytes 0 to NBYTES-1, then CHK = XOR of all payload bytes. The sync byte is not included in CHK.
- Each byte is sent as: start bit (0), data bits LSB first, stop bit (1). Each bit is held for exactly `BAUD_DIV` cycles.
- FSM states:
  - IDLE → START on an accepted `send`.
  - START → DATA after 1 bit time.
  - DATA → STOP after 8 bit times.
  - STOP → START if bytes remain, otherwise → DONE.
  - DONE → IDLE after 1 cycle.
- Counters:
  - baud counter, width clog2(`BAUD_DIV`), wraps at `BAUD_DIV`-1.
  - bit index, 0–7.
  - byte index, 0 to NBYTES+1. Index 0 is sync, indices 1..NBYTES are payload, index NBYTES+1 is CHK.
- Snapshot: a register of `MSG_BITS` bits captures `datagram` on acceptance. Input changes mid-frame have no effect.
- CHK is computed combinationally from the snapshot, or accumulated as bytes are loaded. Either way the transmitted value is identical.
- `send` while `busy`=1 is ignored and not queued.
- `send` in the DONE cycle is accepted (`busy`=0 in that cycle).

## Timing
- Reset values: `TxD`=1, `busy`=0, `done`=0, FSM=IDLE, all counters 0, snapshot 0.
- `send` accepted at edge t:
  - `busy`=1 and `TxD`=0 (start bit) from t+1.
  - No idle gap before the start bit.
- Bytes are sent back to back: the next byte's start bit immediately follows the previous stop bit.
- Frame length: (NBYTES+2)·10·`BAUD_DIV` cycles from t+1.
- `done`=1 and `busy`=0 in the single cycle after the last stop bit's final cycle.
- `TxD`=1 during DONE and IDLE.
- `rst` asserted mid-frame: on the next edge all state returns to reset values (`TxD`=1 immediately). The partial frame is abandoned and `done` is not pulsed.
- `rst` and `send` in the same cycle: reset wins and `send` is dropped.

## Structure
- `NBYTES` is a localparam derived from `MSG_BITS`.
- `SYNC_BYTE` and the FSM state enum (IDLE/START/DATA/STOP/DONE) belong in the shared typedefs/constants package, so the display-side receiver uses the same definitions.
- One natural sub-module: `uart_byte_tx`, a single 8N1 byte shifter with `BAUD_DIV` and a `start`/`busy`/`tx` interface.
  - The framing FSM in `datagram_uart_tx` feeds it bytes and counts them.
  - It mirrors the existing `uart_receiver`.

## Test plan
1. Reset: with `rst` high for 3 cycles → `TxD`=1, `busy`=0, `done`=0. These hold while `send`=0.
2. `MSG_BITS`=16, `BAUD_DIV`=4, `datagram`=16'h3C12, one-cycle `send`:
   - Decoded bytes are A5, 12, 3C, 2E.
   - `busy` is high for exactly 160 cycles, then `done` pulses once.
3. `MSG_BITS`=12, `datagram`=12'hABC → payload bytes BC, 0A, CHK B6. Checks the padding rule.
4. Mid-frame changes: change `datagram` and pulse `send` during the frame → the frame is unchanged and no second frame follows.
   - A `send` held high continuously → back-to-back frames. The new start bit appears in the cycle after `done`.
5. Reset mid-frame: assert `rst` during payload byte 1 → `TxD`=1 and `busy`=0 on the next edge, with no `done`.
   - A subsequent `send` produces a complete, correct frame.
